// File: rtl/tx_sequencer_if.sv
// Readout-side and UART-side handshake bundle for tx_sequencer.
// The slave view belongs to the sequencer; the master view is the surrounding environment.
interface tx_sequencer_if #(
  parameter int unsigned GROUPS = 4
);
  logic                  stb_i;
  logic [8*GROUPS-1:0]   data_i;
  logic [GROUPS-1:0]     dis_i;
  logic                  abort_i;
  logic                  rdy_o;
  logic [7:0]            tx_data_o;
  logic                  tx_stb_o;
  logic                  tx_rdy_i;
  logic                  done_o;

  modport slave (
    input  stb_i, data_i, dis_i, abort_i, tx_rdy_i,
    output rdy_o, tx_data_o, tx_stb_o, done_o
  );

  modport master (
    output stb_i, data_i, dis_i, abort_i, tx_rdy_i,
    input  rdy_o, tx_data_o, tx_stb_o, done_o
  );
endinterface

// File: rtl/tx_sequencer.sv
// Serialises one sample word into bytes for the UART, lowest enabled channel group first,
// skipping groups whose disable flag was set when the word was accepted.
module tx_sequencer #(
  parameter int unsigned GROUPS = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tx_sequencer_if.slave  bus
);
  localparam int unsigned WIDTH = 8 * GROUPS;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [GROUPS-1:0] pend_q, pend_d;

  logic [GROUPS-1:0] cur_oh;
  logic [GROUPS-1:0] pend_left;
  logic [GROUPS-1:0] accept_mask;
  logic [7:0]        cur_byte;

  logic              rdy;
  logic [7:0]        tx_data;
  logic              tx_stb;
  logic              done;

  // Lowest pending group wins: scan downwards so the last hit is the lowest index.
  always_comb begin
    cur_oh   = '0;
    cur_byte = '0;
    for (int unsigned g = GROUPS; g > 0; g--) begin
      if (pend_q[g-1]) begin
        cur_oh        = '0;
        cur_oh[g-1]   = 1'b1;
        cur_byte      = word_q[8*(g-1) +: 8];
      end
    end
  end

  assign pend_left   = pend_q & ~cur_oh;
  assign accept_mask = ~bus.dis_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      word_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (bus.stb_i && !bus.abort_i) begin
          word_d  = bus.data_i;
          pend_d  = accept_mask;
          state_d = (accept_mask == '0) ? FIN : SEND;
        end
      end
      SEND: begin
        // A byte handed off alongside abort still counts as sent; abort only decides where we go.
        if (bus.tx_rdy_i) begin
          pend_d  = pend_left;
          state_d = (pend_left == '0) ? FIN : GAP;
        end
        if (bus.abort_i) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        state_d = bus.abort_i ? IDLE : SEND;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdy     = 1'b0;
    tx_data = '0;
    tx_stb  = 1'b0;
    done    = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: rdy = 1'b1;
        SEND: begin
          tx_data = cur_byte;
          tx_stb  = bus.tx_rdy_i;
        end
        GAP:  tx_data = cur_byte;
        FIN:  done = !bus.abort_i;
        default: rdy = 1'b0;
      endcase
    end
  end

  assign bus.rdy_o     = rdy;
  assign bus.tx_data_o = tx_data;
  assign bus.tx_stb_o  = tx_stb;
  assign bus.done_o    = done;
endmodule

// File: tb/tb_tx_sequencer.sv
// Scoreboard bench for tx_sequencer: expected bytes are queued when a word is issued and
// retired by a monitor as the DUT strobes bytes and pulses done.
module tb_tx_sequencer;
  localparam int unsigned GROUPS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_sequencer_if #(.GROUPS(GROUPS)) bus();

  tx_sequencer #(.GROUPS(GROUPS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit         is_done;
    logic [7:0] b;
  } exp_t;

  typedef enum {RDY_ONE, RDY_ZERO, RDY_RAND} rdy_mode_e;

  exp_t      expq[$];
  int        stb_log[$];
  int        done_log[$];
  int        checks   = 0;
  int        errors   = 0;
  int        cyc      = 0;
  int        last_stb = -100;
  rdy_mode_e rdy_mode = RDY_ONE;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: retires scoreboard entries and checks handshake rules every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_stb = -100;
      chk("reset_tx_stb", bus.tx_stb_o, 0);
      chk("reset_done", bus.done_o, 0);
      chk("reset_rdy", bus.rdy_o, 0);
      chk("reset_tx_data", bus.tx_data_o, 0);
    end else begin
      if (bus.tx_stb_o) begin
        chk("stb_needs_tx_rdy", bus.tx_rdy_i, 1);
        chk("stb_not_with_done", bus.done_o, 0);
        chk("stb_spacing_ge2", (cyc - last_stb) >= 2, 1);
        last_stb = cyc;
        stb_log.push_back(cyc);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h expected no byte (cycle %0d)", bus.tx_data_o, cyc);
        end else begin
          e = expq.pop_front();
          chk("byte_not_done_slot", e.is_done, 0);
          chk("byte_value", bus.tx_data_o, e.b);
        end
      end else if (bus.done_o) begin
        done_log.push_back(cyc);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done expected nothing (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          chk("done_slot", e.is_done, 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      RDY_ONE:  bus.tx_rdy_i = 1'b1;
      RDY_ZERO: bus.tx_rdy_i = 1'b0;
      default:  bus.tx_rdy_i = ($urandom_range(0, 3) != 0);
    endcase
    #1;
  endtask

  // Reference model: enabled groups in ascending order, then one done.
  task automatic push_expect(input logic [31:0] d, input logic [3:0] dis);
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      if (!dis[g]) begin
        e.is_done = 1'b0;
        e.b       = 8'((d >> (8 * g)) & 32'hFF);
        expq.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.b       = '0;
    expq.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] dis, output int t);
    int n = 0;
    while (bus.rdy_o !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("accept_ready_reached", bus.rdy_o, 1);
    bus.stb_i  = 1'b1;
    bus.data_i = d;
    bus.dis_i  = dis;
    t = cyc;
    push_expect(d, dis);
    step();
    bus.stb_i  = 1'b0;
    bus.data_i = $urandom;
    bus.dis_i  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.rdy_o === 1'b1 && expq.size() == 0) && n < 500) begin
      step();
      n++;
    end
    chk("idle_reached", (bus.rdy_o === 1'b1 && expq.size() == 0), 1);
  endtask

  task automatic clear_logs();
    stb_log.delete();
    done_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst         = 1'b1;
    bus.stb_i   = 1'b0;
    bus.data_i  = '0;
    bus.dis_i   = '0;
    bus.abort_i = 1'b0;
    bus.tx_rdy_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rdy_after_release", bus.rdy_o, 1);
    chk("no_stb_after_release", bus.tx_stb_o, 0);

    // All groups enabled, UART always ready.
    rdy_mode = RDY_ONE;
    clear_logs();
    send_word(32'hDDCCBBAA, 4'b0000, t);
    while (cyc < t + 8) step();
    chk("t1_done_at_T8", bus.done_o, 1);
    chk("t1_rdy_low_in_fin", bus.rdy_o, 0);
    step();
    chk("t1_rdy_at_T9", bus.rdy_o, 1);
    chk("t1_strobe_count", stb_log.size(), 4);
    for (int i = 0; i < stb_log.size() && i < 4; i++)
      chk("t1_strobe_cycle", stb_log[i] - t, 2 * i + 1);

    // Groups 1 and 3 disabled.
    clear_logs();
    send_word(32'h44332211, 4'b1010, t);
    wait_idle();
    chk("t2_strobe_count", stb_log.size(), 2);
    if (stb_log.size() == 2 && done_log.size() == 1) begin
      chk("t2_first_strobe", stb_log[0] - t, 1);
      chk("t2_second_strobe", stb_log[1] - t, 3);
      chk("t2_done_after_last", done_log[0] - stb_log[1], 1);
    end

    // Everything disabled.
    clear_logs();
    send_word(32'h5A5A5A5A, 4'b1111, t);
    chk("t3_done_at_T1", bus.done_o, 1);
    chk("t3_no_stb", bus.tx_stb_o, 0);
    step();
    chk("t3_rdy_at_T2", bus.rdy_o, 1);
    chk("t3_strobe_count", stb_log.size(), 0);

    // UART stalls for 10 cycles after the first byte.
    clear_logs();
    send_word(32'hDDCCBBAA, 4'b0000, t);
    chk("t4_first_strobe_T1", bus.tx_stb_o, 1);
    rdy_mode = RDY_ZERO;
    repeat (10) begin
      step();
      chk("t4_no_stb_while_low", bus.tx_stb_o, 0);
      chk("t4_data_stable", bus.tx_data_o, 8'hBB);
    end
    rdy_mode = RDY_ONE;
    step();
    chk("t4_stb_on_rdy_rise", bus.tx_stb_o, 1);
    wait_idle();
    chk("t4_strobe_count", stb_log.size(), 4);

    // Abort in GAP after the first byte, then a single-byte word.
    clear_logs();
    send_word(32'hDDCCBBAA, 4'b0000, t);
    step();
    chk("t5_gap_no_stb", bus.tx_stb_o, 0);
    bus.abort_i = 1'b1;
    expq.delete();
    step();
    bus.abort_i = 1'b0;
    chk("t5_rdy_after_abort", bus.rdy_o, 1);
    repeat (4) begin
      step();
      chk("t5_no_stb_after_abort", bus.tx_stb_o, 0);
      chk("t5_no_done_after_abort", bus.done_o, 0);
    end
    clear_logs();
    send_word(32'h000000EE, 4'b1110, t);
    wait_idle();
    chk("t5_single_strobe", stb_log.size(), 1);
    chk("t5_single_done", done_log.size(), 1);

    // Reset while BB is pending in SEND, with the UART ready during reset.
    clear_logs();
    send_word(32'hDDCCBBAA, 4'b0000, t);
    rdy_mode = RDY_ZERO;
    step();
    step();
    chk("t6_bb_pending", bus.tx_data_o, 8'hBB);
    rst = 1'b1;
    rdy_mode = RDY_ONE;
    bus.tx_rdy_i = 1'b1;
    expq.delete();
    #1;
    chk("t6_reset_no_stb", bus.tx_stb_o, 0);
    chk("t6_reset_no_done", bus.done_o, 0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_rdy_after_release", bus.rdy_o, 1);
    repeat (3) begin
      step();
      chk("t6_no_stb_after_reset", bus.tx_stb_o, 0);
    end

    // Strobes from the readout path while busy must be ignored.
    clear_logs();
    send_word(32'h87654321, 4'b0000, t);
    repeat (8) begin
      if (bus.rdy_o === 1'b0) begin
        bus.stb_i  = 1'b1;
        bus.data_i = $urandom;
        bus.dis_i  = '0;
      end
      step();
      bus.stb_i = 1'b0;
    end
    wait_idle();
    chk("t6_busy_pokes_ignored", stb_log.size(), 4);

    // Randomised words, masks and UART readiness.
    rdy_mode = RDY_RAND;
    repeat (40) begin
      logic [31:0] d;
      logic [3:0]  dis;
      d   = $urandom;
      dis = 4'($urandom_range(0, 15));
      send_word(d, dis, t);
      if ($urandom_range(0, 1) == 1) begin
        repeat (3) begin
          if (bus.rdy_o === 1'b0) begin
            bus.stb_i  = 1'b1;
            bus.data_i = $urandom;
          end
          step();
          bus.stb_i = 1'b0;
        end
      end
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();
    chk("queue_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tx_sequencer.md
Name: tx_sequencer

Overview:
- Serialises one captured sample word from the readout path into bytes for the UART transmitter.
- Sits between ctrl/sample memory readout and the UART TX.
- Honours the SUMP channel-group disable flags: disabled groups are skipped and never transmitted.
- Enabled bytes go out group 0 first, using a strobe/ready handshake on both sides.

Parameters:
- GROUPS, 4, number of 8-bit channel groups per sample word.
- WIDTH, 8*GROUPS, sample word width in bits (derived; not overridden independently).

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- stb_i  in  1  sample word valid from readout path
- data_i  in  WIDTH  sample word; group g = data_i[8g+7:8g]
- dis_i  in  GROUPS  group disable mask (1 = skip group), sampled with the word
- abort_i  in  1  cancel current word (ctrl reset / new command)
- rdy_o  out  1  block idle, word accepted when stb_i && rdy_o
- tx_data_o  out  8  byte to UART
- tx_stb_o  out  1  one-cycle byte strobe to UART
- tx_rdy_i  in  1  UART idle, can accept a byte
- done_o  out  1  one-cycle pulse: word fully transmitted (or fully skipped)

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Next state IDLE.
  - tx_stb_o=0, done_o=0, tx_data_o=0, rdy_o=0 during the reset cycle.
  - rdy_o=1 from the first cycle after release.
  - Internal word/mask registers cleared.
  - Reset overrides every other input, including mid-word.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - rdy_o=1.
  - On stb_i=1: latch data_i into word reg and ~dis_i into pending mask; go to SEND.
  - If the mask is all zero: go to FIN instead.
  - stb_i while rdy_o=0 is ignored and not queued.
- SEND:
  - rdy_o=0.
  - Current group = lowest set bit of pending mask; tx_data_o = that byte, held stable for the whole state.
  - Cycle with tx_rdy_i=1: tx_stb_o=1 for exactly that cycle, clear the group's pending bit.
  - After the strobe: go to GAP if any pending bit remains, otherwise FIN.
  - tx_rdy_i=0: stay in SEND, no strobe, unbounded wait.
- GAP:
  - One guard cycle with no strobe, so UART tx_rdy_i can fall.
  - tx_rdy_i is ignored; always go to SEND.
- FIN:
  - done_o=1 for one cycle; go to IDLE.
  - rdy_o stays 0 in FIN and is 1 in the following cycle.
- Timing:
  - Accept at cycle T; earliest first strobe at T+1.
  - Minimum spacing between consecutive strobes is 2 cycles.
  - done_o occurs one cycle after the last strobe; all-disabled word gives done_o at T+1.
- abort_i:
  - In SEND/GAP/FIN: go to IDLE next cycle, no further strobes, no done_o.
  - A strobe coinciding with abort_i in SEND is still issued (byte already handed off); abort wins for the next state.
  - In IDLE: blocks acceptance that cycle.
- Outputs:
  - tx_stb_o and done_o are never high in the same cycle.
  - tx_stb_o is never high while tx_rdy_i=0.
- Byte count per word = popcount(~dis_i) at acceptance. Later dis_i changes do not affect the word in flight.
- Priority encoder must handle any GROUPS up to 8.

Test Plan:
- dis_i=4'b0000, data_i=32'hDDCCBBAA accepted at T, tx_rdy_i held 1 -> tx_stb_o at T+1,T+3,T+5,T+7 with tx_data_o AA,BB,CC,DD; done_o at T+8; rdy_o=1 at T+9.
- dis_i=4'b1010, data_i=32'h44332211, tx_rdy_i=1 -> exactly two strobes, bytes 11 then 33; done_o one cycle after second strobe.
- dis_i=4'b1111 accepted at T -> no tx_stb_o; done_o at T+1; rdy_o=1 at T+2.
- dis_i=0, tx_rdy_i=0 for 10 cycles after the first strobe -> no strobe while low; tx_data_o=BB stable throughout; strobe in the first cycle tx_rdy_i=1; all 4 bytes in order.
- abort_i pulsed in GAP after byte AA -> no further strobes, no done_o, rdy_o=1 next cycle; following word 32'h0000_00EE with dis_i=4'b1110 -> single strobe EE, then done_o.
- rst_i asserted while in SEND (byte BB pending) -> tx_stb_o=0, done_o=0 in reset cycle; rdy_o=1 after release; stb_i pulses while busy in another run are ignored, with no extra strobes.
